// File: rtl/sprite_draw.sv
// rtl/sprite_draw.sv - Chip-8 DXYN sprite draw engine: fetch rows, XOR into framebuffer, flag collisions
module sprite_draw (
    input  logic        clk,
    input  logic        res,
    input  logic        hires,
    input  logic        start,
    input  logic [6:0]  x,
    input  logic [5:0]  y,
    input  logic [3:0]  height,
    input  logic [11:0] spriteAddr,
    output logic [11:0] memAddr,
    input  logic [7:0]  memData,
    output logic [8:0]  fbAddr,
    input  logic [15:0] fbRdata,
    output logic [15:0] fbWdata,
    output logic        fbWe,
    output logic        busy,
    output logic        done,
    output logic        collision
);
    typedef enum logic [3:0] {
        IDLE, MEM0, MEM1, MEM2, FB0, FB1, FB2, WR0, WR1, DONE
    } state_t;

    state_t      state;
    logic        hiresR;
    logic        wideR;
    logic [6:0]  xp;
    logic [5:0]  yp;
    logic [3:0]  lastRow;
    logic [3:0]  rowIdx;
    logic        pass;
    logic [11:0] curAddr;
    logic [7:0]  byte0;
    logic [15:0] rowPat;
    logic [15:0] old0;
    logic [15:0] old1;

    logic [31:0] shifted;
    logic [15:0] pat0;
    logic [15:0] pat1;
    logic [2:0]  w0;
    logic [2:0]  w1;
    logic [5:0]  line;
    logic [15:0] doubled;

    always_comb begin
        shifted = {rowPat, 16'h0000} >> xp[3:0];
        pat0    = shifted[31:16];
        pat1    = shifted[15:0];
        w0      = xp[6:4];
        w1      = w0 + 3'd1;
        // Lores rows cover two framebuffer lines; pass selects the lower one.
        if (hiresR)
            line = yp + {2'b00, rowIdx};
        else
            line = yp + {1'b0, rowIdx, 1'b0} + {5'b00000, pass};
        doubled = 16'h0000;
        for (int i = 0; i < 8; i++)
            doubled[2*i +: 2] = {2{memData[i]}};
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= IDLE;
            hiresR    <= 1'b0;
            wideR     <= 1'b0;
            xp        <= '0;
            yp        <= '0;
            lastRow   <= '0;
            rowIdx    <= '0;
            pass      <= 1'b0;
            curAddr   <= '0;
            byte0     <= '0;
            rowPat    <= '0;
            old0      <= '0;
            old1      <= '0;
            memAddr   <= '0;
            fbAddr    <= '0;
            fbWdata   <= '0;
            fbWe      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            collision <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        hiresR    <= hires;
                        wideR     <= hires && (height == 4'd0);
                        xp        <= hires ? x : {x[5:0], 1'b0};
                        yp        <= hires ? y : {y[4:0], 1'b0};
                        // height 0 wraps to 15, giving the 16-row sprite for free
                        lastRow   <= height - 4'd1;
                        rowIdx    <= '0;
                        pass      <= 1'b0;
                        memAddr   <= spriteAddr;
                        curAddr   <= spriteAddr + 12'd1;
                        collision <= 1'b0;
                        busy      <= 1'b1;
                        state     <= MEM0;
                    end
                end
                MEM0: begin
                    if (wideR) begin
                        memAddr <= curAddr;
                        curAddr <= curAddr + 12'd1;
                    end
                    state <= MEM1;
                end
                MEM1: begin
                    if (wideR) begin
                        byte0 <= memData;
                        state <= MEM2;
                    end else begin
                        rowPat <= hiresR ? {memData, 8'h00} : doubled;
                        fbAddr <= {line, w0};
                        state  <= FB0;
                    end
                end
                MEM2: begin
                    rowPat <= {byte0, memData};
                    fbAddr <= {line, w0};
                    state  <= FB0;
                end
                FB0: begin
                    fbAddr <= {line, w1};
                    state  <= FB1;
                end
                FB1: begin
                    old0      <= fbRdata;
                    collision <= collision | (|(fbRdata & pat0));
                    state     <= FB2;
                end
                FB2: begin
                    old1      <= fbRdata;
                    collision <= collision | (|(fbRdata & pat1));
                    fbAddr    <= {line, w0};
                    fbWdata   <= old0 ^ pat0;
                    fbWe      <= 1'b1;
                    state     <= WR0;
                end
                WR0: begin
                    fbAddr  <= {line, w1};
                    fbWdata <= old1 ^ pat1;
                    state   <= WR1;
                end
                WR1: begin
                    fbWe <= 1'b0;
                    if (!hiresR && !pass) begin
                        pass   <= 1'b1;
                        fbAddr <= {line + 6'd1, w0};
                        state  <= FB0;
                    end else begin
                        pass <= 1'b0;
                        if (rowIdx == lastRow) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            rowIdx  <= rowIdx + 4'd1;
                            memAddr <= curAddr;
                            curAddr <= curAddr + 12'd1;
                            state   <= MEM0;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
